v_mask_accum: RTL

- Receiving end of the mask-compare result stream.
- Each compare beat carries a partial mask word: result bits, per-bit enables and a destination mask-register address.
- A vector op with LMUL/VL spanning several source beats therefore writes the same mask word several times with disjoint bit ranges.
- This block merges those partial beats into one mask word per address and issues a single write to the register-file writeback port, with valid/ready backpressure.

---
 rtl/v_mask_accum.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/v_mask_accum.sv
// Merges partial mask-compare beats that target the same mask word into a
// single register-file write, with valid/ready flow control on both sides.
module v_mask_accum #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_vec,
    input  logic [DATA_WIDTH-1:0] in_bit_en,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_vec,
    output logic [BE_WIDTH-1:0]   out_be
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_n;

    logic [DATA_WIDTH-1:0] acc_vec, acc_en;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] hold_vec, hold_en;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic                  hold_last, hold_vld;

    logic in_fire, out_fire, addr_match;
    logic load_in, merge_in, store_hold, load_hold, clear_acc;

    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign addr_match = (in_addr == acc_addr);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_n    = state;
        load_in    = 1'b0;
        merge_in   = 1'b0;
        store_hold = 1'b0;
        load_hold  = 1'b0;
        clear_acc  = 1'b0;
        case (state)
            IDLE: begin
                // A last beat that enables nothing carries no data; drop it.
                if (in_fire && !(in_bit_en == '0 && in_last)) begin
                    load_in = 1'b1;
                    state_n = in_last ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (in_fire) begin
                    if (addr_match) begin
                        merge_in = 1'b1;
                        if (in_last) state_n = DRAIN;
                    end else begin
                        store_hold = 1'b1;
                        state_n    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if (hold_vld) begin
                        load_hold = 1'b1;
                        state_n   = hold_last ? DRAIN : ACCUM;
                    end else begin
                        clear_acc = 1'b1;
                        state_n   = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
        end else begin
            state    <= state_n;
            in_ready <= (state_n != DRAIN);
        end
    end

    // NOTE: the accumulator and hold register are reset so a reset mid-op
    // can never leak stale partial data into a later write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_vec   <= '0;
            acc_en    <= '0;
            acc_addr  <= '0;
            hold_vec  <= '0;
            hold_en   <= '0;
            hold_addr <= '0;
            hold_last <= 1'b0;
            hold_vld  <= 1'b0;
        end else begin
            if (load_in) begin
                acc_vec  <= in_vec & in_bit_en;
                acc_en   <= in_bit_en;
                acc_addr <= in_addr;
            end else if (merge_in) begin
                acc_vec <= (acc_vec & ~in_bit_en) | (in_vec & in_bit_en);
                acc_en  <= acc_en | in_bit_en;
            end else if (load_hold) begin
                acc_vec  <= hold_vec;
                acc_en   <= hold_en;
                acc_addr <= hold_addr;
            end else if (clear_acc) begin
                acc_vec  <= '0;
                acc_en   <= '0;
                acc_addr <= '0;
            end

            if (store_hold) begin
                hold_vec  <= in_vec & in_bit_en;
                hold_en   <= in_bit_en;
                hold_addr <= in_addr;
                hold_last <= in_last;
                hold_vld  <= 1'b1;
            end else if (load_hold) begin
                hold_vld <= 1'b0;
            end
        end
    end

    assign out_valid = (state == DRAIN);
    assign out_addr  = acc_addr;
    assign out_vec   = acc_vec;

    for (genvar k = 0; k < BE_WIDTH; k++) begin : g_be
        assign out_be[k] = |acc_en[8*k +: 8];
    end

endmodule
